// File: rtl/touch_pkg.sv
// touch_pkg: shared types and helpers for the touch-key LED array.
// Key debounce FSM states and the millisecond-to-cycle conversion used to
// size the debounce and long-press counters.
package touch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_D = 2'd1,
        HELD    = 2'd2,
        REL_D   = 2'd3
    } key_fsm_e;

    // Converts a duration in ms to sys_clk cycles; never returns less than 1
    // so a debounce or hold time of zero still yields a usable counter.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        int cycles;
        cycles = (clk_hz / 1000) * ms;
        if (cycles < 1) begin
            cycles = 1;
        end
        return cycles;
    endfunction

endpackage

// File: rtl/touch_key_chan.sv
// touch_key_chan: one touch-key channel.
// Two-flop synchroniser, press/release debounce FSM, press strobe, toggle bit
// and the registered LED-on decision (polarity is applied by the top).
// Optional build macro TOUCH_LONG_PRESS_EN adds a long-press counter and strobe.
module touch_key_chan
    import touch_pkg::*;
#(
    parameter int DEB_CYCLES  = 4
`ifdef TOUCH_LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES = 20
`endif
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic touch_key_i,
    input  logic mode_i,
    input  logic clear_i,
    output logic key_pulse_o,
    output logic key_state_o,
`ifdef TOUCH_LONG_PRESS_EN
    output logic long_press_o,
`endif
    output logic led_on_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    key_fsm_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_pulse;
    logic          key_state;
    logic          toggle_q, toggle_d;
    logic          led_on_q, led_on_d;
    logic          lp_hit;

    // Bring the asynchronous key into the sys_clk domain.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= touch_key_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce state and stability counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce transitions; the press strobe and level are decided in the
    // same cycle the counter expires so downstream logic sees them early.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_pulse = 1'b0;
        key_state = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_D;
                    cnt_d   = '0;
                end
            end
            PRESS_D: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    key_pulse = 1'b1;
                    key_state = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                key_state = 1'b1;
                if (!sync2_q) begin
                    state_d = REL_D;
                    cnt_d   = '0;
                end
            end
            REL_D: begin
                key_state = 1'b1;
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    key_state = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef TOUCH_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LP_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LP_FULL = LW'(LONG_CYCLES);

    logic [LW-1:0] lp_cnt_q, lp_cnt_d;
    logic          long_press_q;

    // Hold-time counter: runs only in HELD and saturates, so one hold gives
    // at most one strobe even if a short release bounce returns to HELD.
    always_comb begin
        lp_cnt_d = lp_cnt_q;
        lp_hit   = 1'b0;
        if (state_q == IDLE || state_q == PRESS_D) begin
            lp_cnt_d = '0;
        end else if (state_q == HELD && lp_cnt_q != LP_FULL) begin
            lp_cnt_d = lp_cnt_q + 1'b1;
            lp_hit   = (lp_cnt_q == LP_LAST);
        end
    end

    // Long-press counter and registered strobe.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lp_cnt_q     <= '0;
            long_press_q <= 1'b0;
        end else begin
            lp_cnt_q     <= lp_cnt_d;
            long_press_q <= lp_hit;
        end
    end

    assign long_press_o = long_press_q;
`else
    assign lp_hit = 1'b0;
`endif

    // Toggle bit and LED decision; clear has the final say over the toggle.
    always_comb begin
        toggle_d = toggle_q ^ key_pulse;
        if (lp_hit && !mode_i) begin
            toggle_d = 1'b0;
        end
        if (clear_i) begin
            toggle_d = 1'b0;
        end
        led_on_d = mode_i ? key_state : toggle_d;
    end

    // Registered toggle bit and LED-on level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            toggle_q <= 1'b0;
            led_on_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
            led_on_q <= led_on_d;
        end
    end

    assign key_pulse_o = key_pulse;
    assign key_state_o = key_state;
    assign led_on_o    = led_on_q;

endmodule

// File: rtl/touch_led_array.sv
// touch_led_array: NUM_KEYS independent touch-key channels driving LEDs.
// Each channel is a touch_key_chan; this level sizes the counters from the
// clock frequency and applies the board LED polarity.
// Optional build macro TOUCH_LONG_PRESS_EN enables the long_press outputs.
module touch_led_array
    import touch_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int DEBOUNCE_MS    = 10,
    parameter int LONG_PRESS_MS  = 1000,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] touch_key,
    input  logic [NUM_KEYS-1:0] mode,
    input  logic                clear,
    output logic [NUM_KEYS-1:0] led,
    output logic [NUM_KEYS-1:0] key_pulse,
`ifdef TOUCH_LONG_PRESS_EN
    output logic [NUM_KEYS-1:0] long_press,
`endif
    output logic [NUM_KEYS-1:0] key_state
);

    localparam int DEB_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
`ifdef TOUCH_LONG_PRESS_EN
    localparam int LONG_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
`endif

    logic [NUM_KEYS-1:0] led_on;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        touch_key_chan #(
            .DEB_CYCLES  (DEB_CYCLES)
`ifdef TOUCH_LONG_PRESS_EN
            ,
            .LONG_CYCLES (LONG_CYCLES)
`endif
        ) u_chan (
            .sys_clk      (sys_clk),
            .sys_rst_n    (sys_rst_n),
            .touch_key_i  (touch_key[i]),
            .mode_i       (mode[i]),
            .clear_i      (clear),
            .key_pulse_o  (key_pulse[i]),
            .key_state_o  (key_state[i]),
`ifdef TOUCH_LONG_PRESS_EN
            .long_press_o (long_press[i]),
`endif
            .led_on_o     (led_on[i])
        );
    end

    // Reset leaves led_on at 0, so an active-low board sees all LEDs off.
    assign led = (LED_ACTIVE_LOW != 0) ? ~led_on : led_on;

endmodule

// File: tb/tb_touch_led_array.sv
// tb_touch_led_array: scoreboard bench for touch_led_array.
// A run-length reference model predicts each cycle's outputs from the bench's
// own stimulus; a negedge monitor pops and compares them.
module tb_touch_led_array;

    localparam int NK    = 4;
    localparam int DEB   = 4;
    localparam int LONGC = 20;

    typedef struct {
        logic [NK-1:0] pulse;
        logic [NK-1:0] state;
        logic [NK-1:0] led;
        logic [NK-1:0] lp;
        int            cyc;
    } expT;

    logic          sysClk   = 1'b0;
    logic          sysRstN  = 1'b0;
    logic [NK-1:0] touchKey = '0;
    logic [NK-1:0] modeIn   = '0;
    logic          clearIn  = 1'b0;
    logic [NK-1:0] led;
    logic [NK-1:0] keyPulse;
    logic [NK-1:0] keyState;
`ifdef TOUCH_LONG_PRESS_EN
    logic [NK-1:0] longPress;
`endif

    // model state
    logic [NK-1:0] deb, toggle, ledOnReg, lpPend, tkPrev1, tkPrev2;
    int            run[NK];
    int            heldCnt[NK];
    int            expPulses[NK];
    int            dutPulses[NK];
    int            cycleNo;
    expT           expQ[$];
    int            assertCount;
    int            failCount;

    touch_led_array #(
        .NUM_KEYS       (NK),
        .CLK_FREQ_HZ    (1000),
        .DEBOUNCE_MS    (4),
        .LONG_PRESS_MS  (LONGC),
        .LED_ACTIVE_LOW (1)
    ) dut (
        .sys_clk    (sysClk),
        .sys_rst_n  (sysRstN),
        .touch_key  (touchKey),
        .mode       (modeIn),
        .clear      (clearIn),
        .led        (led),
        .key_pulse  (keyPulse),
`ifdef TOUCH_LONG_PRESS_EN
        .long_press (longPress),
`endif
        .key_state  (keyState)
    );

    always #5 sysClk = ~sysClk;

    task automatic modelReset();
        deb      = '0;
        toggle   = '0;
        ledOnReg = '0;
        lpPend   = '0;
        tkPrev1  = '0;
        tkPrev2  = '0;
        for (int i = 0; i < NK; i++) begin
            run[i]     = 0;
            heldCnt[i] = 0;
        end
    endtask

    // One clock interval of stimulus; the model predicts this interval's outputs.
    task automatic applyStimulus(input logic [NK-1:0] tk, input logic [NK-1:0] md, input logic clr);
        expT           e;
        logic [NK-1:0] s;
        logic [NK-1:0] ledOnNext;
        logic [NK-1:0] toggleNext;
        logic [NK-1:0] lpNext;
        logic          inHeld;
        @(posedge sysClk);
        #1;
        sysRstN  = 1'b1;
        touchKey = tk;
        modeIn   = md;
        clearIn  = clr;
        cycleNo++;
        s       = tkPrev2;
        e.led   = ~ledOnReg;
        e.lp    = lpPend;
        e.cyc   = cycleNo;
        e.pulse = '0;
        lpNext  = '0;
        for (int i = 0; i < NK; i++) begin
            inHeld = deb[i] && (run[i] == 0);
            if (inHeld && heldCnt[i] < LONGC) begin
                heldCnt[i]++;
                if (heldCnt[i] == LONGC) lpNext[i] = 1'b1;
            end
            if (s[i] != deb[i]) run[i]++;
            else run[i] = 0;
            if (run[i] == DEB + 1) begin
                deb[i] = s[i];
                run[i] = 0;
                if (s[i]) begin
                    e.pulse[i] = 1'b1;
                    expPulses[i]++;
                end else begin
                    heldCnt[i] = 0;
                end
            end
            toggleNext[i] = toggle[i] ^ e.pulse[i];
`ifdef TOUCH_LONG_PRESS_EN
            if (lpNext[i] && !md[i]) toggleNext[i] = 1'b0;
`endif
            if (clr) toggleNext[i] = 1'b0;
            ledOnNext[i] = md[i] ? deb[i] : toggleNext[i];
        end
        e.state = deb;
        expQ.push_back(e);
        ledOnReg = ledOnNext;
        toggle   = toggleNext;
        lpPend   = lpNext;
        tkPrev2  = tkPrev1;
        tkPrev1  = tk;
    endtask

    task automatic hold(input logic [NK-1:0] tk, input logic [NK-1:0] md, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tk, md, 1'b0);
    endtask

    task automatic checkOutput(input expT e);
        logic bad;
        assertCount++;
        bad = (keyPulse !== e.pulse) || (keyState !== e.state) || (led !== e.led);
`ifdef TOUCH_LONG_PRESS_EN
        if (longPress !== e.lp) bad = 1'b1;
`endif
        if (bad) begin
            failCount++;
            $display("[TB] FAIL scoreboard cycle %0d: pulse/state/led got %b/%b/%b expected %b/%b/%b",
                     e.cyc, keyPulse, keyState, led, e.pulse, e.state, e.led);
`ifdef TOUCH_LONG_PRESS_EN
            $display("[TB]   long_press got %b expected %b", longPress, e.lp);
`endif
        end
    endtask

    task automatic checkReset(input string name);
        logic bad;
        assertCount++;
        bad = (keyPulse !== '0) || (keyState !== '0) || (led !== '1);
`ifdef TOUCH_LONG_PRESS_EN
        if (longPress !== '0) bad = 1'b1;
`endif
        if (bad) begin
            failCount++;
            $display("[TB] FAIL %s: pulse/state/led got %b/%b/%b expected 0000/0000/1111",
                     name, keyPulse, keyState, led);
        end
    endtask

    // Asynchronous reset in mid-cycle; outputs must collapse straight away.
    task automatic resetPulse(input string name);
        @(posedge sysClk);
        #3;
        sysRstN = 1'b0;
        #1;
        checkReset(name);
        modelReset();
        repeat (2) @(posedge sysClk);
    endtask

    // Monitor: compare every predicted interval and tally observed strobes.
    always @(negedge sysClk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
        for (int i = 0; i < NK; i++) begin
            if (keyPulse[i] === 1'b1) dutPulses[i]++;
        end
    end

    initial begin
        int            remain[NK];
        logic [NK-1:0] rk;
        logic [NK-1:0] rm;
        assertCount = 0;
        failCount   = 0;
        cycleNo     = 0;
        for (int i = 0; i < NK; i++) begin
            expPulses[i] = 0;
            dutPulses[i] = 0;
        end
        modelReset();
        repeat (3) @(posedge sysClk);
        #2;
        checkReset("resetState");

        $display("[TB] single press latency on channel 0");
        hold(4'b0001, 4'b0000, 12);
        hold(4'b0000, 4'b0000, 10);

        $display("[TB] toggle mode: two presses on channel 0");
        hold(4'b0001, 4'b0000, 8);
        hold(4'b0000, 4'b0000, 8);
        hold(4'b0001, 4'b0000, 8);
        hold(4'b0000, 4'b0000, 8);

        $display("[TB] glitch and release gap on channel 1");
        hold(4'b0010, 4'b0000, 3);
        hold(4'b0000, 4'b0000, 8);
        hold(4'b0010, 4'b0000, 8);
        hold(4'b0000, 4'b0000, 3);
        hold(4'b0010, 4'b0000, 8);
        hold(4'b0000, 4'b0000, 10);

        $display("[TB] momentary mode on channel 2");
        hold(4'b0000, 4'b0100, 2);
        hold(4'b0100, 4'b0100, 10);
        hold(4'b0000, 4'b0100, 10);
        hold(4'b0000, 4'b0000, 2);

        $display("[TB] clear coinciding with press strobe on channel 3");
        for (int i = 0; i < 12; i++) applyStimulus(4'b1000, 4'b0000, i == 6);
        hold(4'b0000, 4'b0000, 10);

        $display("[TB] all keys together");
        hold(4'b1111, 4'b0000, 8);
        hold(4'b0000, 4'b0000, 10);

        $display("[TB] long hold then reset mid-hold");
        hold(4'b0001, 4'b0000, 35);
        resetPulse("midHoldReset");
        hold(4'b0001, 4'b0000, 12);
        hold(4'b0000, 4'b0000, 10);

        $display("[TB] randomized traffic");
        rk = '0;
        rm = '0;
        for (int i = 0; i < NK; i++) remain[i] = $urandom_range(1, 8);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NK; i++) begin
                remain[i]--;
                if (remain[i] <= 0) begin
                    rk[i] = ~rk[i];
                    remain[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 30) : $urandom_range(1, 8);
                end
            end
            if ($urandom_range(0, 49) == 0) rm = NK'($urandom);
            if (c == 400) resetPulse("randomReset");
            applyStimulus(rk, rm, $urandom_range(0, 39) == 0);
        end
        hold(4'b0000, 4'b0000, 12);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge sysClk);
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d entries left, required 0", expQ.size());
        end
        @(posedge sysClk);
        for (int i = 0; i < NK; i++) begin
            assertCount++;
            if (dutPulses[i] != expPulses[i]) begin
                failCount++;
                $display("[TB] FAIL pulseCount ch%0d: got %0d expected %0d", i, dutPulses[i], expPulses[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
